// File: rtl/digit_sink_pkg.sv
// Shared lane state encoding and dual-rail code points for the digit-counter sink.
package digit_sink_pkg;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAITNULL = 2'd1,
        HELD     = 2'd2
    } lane_state_e;

    localparam logic [1:0] RAIL_NULL    = 2'b00;
    localparam logic [1:0] RAIL_D0      = 2'b01;
    localparam logic [1:0] RAIL_D1      = 2'b10;
    localparam logic [1:0] RAIL_ILLEGAL = 2'b11;

endpackage

// File: rtl/digit_sink_lane.sv
// One dual-rail digit: rail synchroniser, completeness FSM and captured bit.
// state    | meaning
// REQ      | sumcomp=0, waiting for a DATA code on the synchronised rails
// WAITNULL | sumcomp=1, bit captured, waiting for the rails to return to NULL
// HELD     | sumcomp=1, digit complete, parked until the word is launched
module digit_sink_lane
    import digit_sink_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       init,
    input  logic [1:0] rails,
    input  logic       launch,
    output logic       sumcomp,
    output logic       held,
    output logic       bit_val,
    output logic       code_err
);

    logic [1:0]  sync_q [SYNC_STAGES];
    logic [1:0]  r;
    lane_state_e state;

    always_ff @(posedge clk) begin
        if (init) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= RAIL_NULL;
        end else begin
            sync_q[0] <= rails;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign r = sync_q[SYNC_STAGES-1];

    // Launch wins over everything: the whole word has been taken, so every lane re-arms.
    always_ff @(posedge clk) begin
        if (init) begin
            state    <= REQ;
            sumcomp  <= 1'b0;
            held     <= 1'b0;
            bit_val  <= 1'b0;
            code_err <= 1'b0;
        end else begin
            code_err <= (r == RAIL_ILLEGAL);
            if (launch) begin
                state   <= REQ;
                sumcomp <= 1'b0;
                held    <= 1'b0;
            end else begin
                case (state)
                    REQ: begin
                        if (r == RAIL_D0 || r == RAIL_D1) begin
                            bit_val <= r[1];
                            state   <= WAITNULL;
                            sumcomp <= 1'b1;
                        end
                    end
                    WAITNULL: begin
                        if (r == RAIL_NULL) begin
                            state <= HELD;
                            held  <= 1'b1;
                        end
                    end
                    HELD: ;
                    default: begin
                        state   <= REQ;
                        sumcomp <= 1'b0;
                        held    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/digit_counter_sink.sv
// Clocked sink for the dual-rail NCL digit-counter ring: collects one wavefront per
// digit, presents the assembled word on valid/ready and checks successive counts.
module digit_counter_sink
    import digit_sink_pkg::*;
#(
    parameter int DIGITS      = 32,
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_SEQ   = 1
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic [2*DIGITS-1:0]   sum_in,
    output logic [DIGITS-1:0]     sumcomp,
    output logic [DIGITS-1:0]     word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  seq_error,
    output logic                  code_error
);

    localparam logic [DIGITS-1:0] ONE = DIGITS'(1);

    logic [DIGITS-1:0] held_vec;
    logic [DIGITS-1:0] bits;
    logic [DIGITS-1:0] code_vec;
    logic [DIGITS-1:0] prev_word;
    logic [DIGITS-1:0] next_expected;
    logic              first_word;
    logic              launch;

    for (genvar g = 0; g < DIGITS; g++) begin : g_lane
        digit_sink_lane #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_lane (
            .clk      (clk),
            .init     (init),
            .rails    (sum_in[2*g+1:2*g]),
            .launch   (launch),
            .sumcomp  (sumcomp[g]),
            .held     (held_vec[g]),
            .bit_val  (bits[g]),
            .code_err (code_vec[g])
        );
    end

    assign launch        = (&held_vec) && (!word_valid || word_ready);
    assign next_expected = prev_word + ONE;

    always_ff @(posedge clk) begin
        if (init) begin
            word       <= '0;
            word_valid <= 1'b0;
            prev_word  <= '0;
            first_word <= 1'b1;
            seq_error  <= 1'b0;
            code_error <= 1'b0;
        end else begin
            if (launch) begin
                word       <= bits;
                word_valid <= 1'b1;
                prev_word  <= bits;
                first_word <= 1'b0;
                if ((CHECK_SEQ != 0) && !first_word && (bits != next_expected))
                    seq_error <= 1'b1;
            end else if (word_ready) begin
                word_valid <= 1'b0;
            end
            if (|code_vec)
                code_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_digit_counter_sink.sv
// Scoreboard bench for digit_counter_sink: directed wavefronts plus randomized words,
// skew and backpressure, checked against a count-level reference model.
module tb_digit_counter_sink;

    localparam int DIGITS = 32;
    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    logic                 clk = 1'b0;
    logic                 init;
    logic [2*DIGITS-1:0]  sum_in;
    logic [DIGITS-1:0]    sumcomp;
    logic [DIGITS-1:0]    word;
    logic                 word_valid;
    logic                 word_ready;
    logic                 seq_error;
    logic                 code_error;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] m_prev;
    bit          m_first;
    bit          m_seq;
    bit          rand_ready = 1'b0;

    digit_counter_sink #(
        .DIGITS(DIGITS), .SYNC_STAGES(2), .CHECK_SEQ(1)
    ) dut (
        .clk        (clk),
        .init       (init),
        .sum_in     (sum_in),
        .sumcomp    (sumcomp),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .seq_error  (seq_error),
        .code_error (code_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a word is consumed at the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (init === 1'b0 && word_valid === 1'b1 && word_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h expected none", word);
            end else begin
                check("word", {32'd0, word}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            word_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [31:0] w);
        logic [31:0] nxt;
        nxt = m_prev + 32'd1;
        exp_q.push_back(w);
        if (!m_first && w != nxt) m_seq = 1'b1;
        m_prev  = w;
        m_first = 1'b0;
    endtask

    task automatic set_data(input logic [31:0] w, input logic [31:0] mask);
        for (int i = 0; i < DIGITS; i++)
            if (mask[i]) sum_in[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
    endtask

    task automatic set_null(input logic [31:0] mask);
        for (int i = 0; i < DIGITS; i++)
            if (mask[i]) sum_in[2*i +: 2] = 2'b00;
    endtask

    task automatic do_reset();
        init   = 1'b1;
        sum_in = {$urandom, $urandom};
        tick(2);
        check("rst_sumcomp", {32'd0, sumcomp}, 64'd0);
        check("rst_valid", {63'd0, word_valid}, 64'd0);
        check("rst_word", {32'd0, word}, 64'd0);
        check("rst_seq", {63'd0, seq_error}, 64'd0);
        check("rst_code", {63'd0, code_error}, 64'd0);
        init    = 1'b0;
        sum_in  = '0;
        exp_q.delete();
        m_prev  = '0;
        m_first = 1'b1;
        m_seq   = 1'b0;
        tick(1);
    endtask

    task automatic wait_held(input string name);
        int n = 0;
        while (sumcomp !== ALL1 && n < 40) begin
            tick(1);
            n++;
        end
        check(name, {32'd0, sumcomp}, {32'd0, ALL1});
    endtask

    task automatic wait_launch(input string name);
        int n = 0;
        while (sumcomp !== 32'd0 && n < 200) begin
            tick(1);
            n++;
        end
        check(name, {32'd0, sumcomp}, 64'd0);
        check({name, "_valid"}, {63'd0, word_valid}, 64'd1);
    endtask

    task automatic wavefront(input logic [31:0] w, input logic [31:0] mask,
                             input int d1, input int d2);
        set_data(w, mask);
        tick(d1);
        set_data(w, ~mask);
        wait_held("wf_held");
        set_null(mask);
        tick(d2);
        set_null(~mask);
        model_push(w);
        wait_launch("wf_launch");
        check("wf_seq", {63'd0, seq_error}, {63'd0, m_seq});
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] mask;
        bit          bad;
        int          n;

        init       = 1'b1;
        word_ready = 1'b0;
        sum_in     = '0;
        do_reset();

        // single word, exact latency
        word_ready = 1'b1;
        set_data(32'd5, ALL1);
        tick(2);
        check("lat_early", {32'd0, sumcomp}, 64'd0);
        tick(1);
        check("lat_sumcomp", {32'd0, sumcomp}, {32'd0, ALL1});
        set_null(ALL1);
        model_push(32'd5);
        tick(3);
        check("held_no_valid", {63'd0, word_valid}, 64'd0);
        tick(1);
        check("single_valid", {63'd0, word_valid}, 64'd1);
        check("single_word", {32'd0, word}, 64'd5);
        check("single_drop", {32'd0, sumcomp}, 64'd0);
        tick(1);
        check("single_consumed", {63'd0, word_valid}, 64'd0);

        // skew: digit 0 finishes 20 clk early
        set_data(32'd6, 32'd1);
        tick(4);
        check("skew_d0_ack", {32'd0, sumcomp}, 64'd1);
        set_null(32'd1);
        bad = 1'b0;
        repeat (20) begin
            tick(1);
            if (sumcomp !== 32'd1 || word_valid !== 1'b0) bad = 1'b1;
        end
        check("skew_park", {63'd0, bad}, 64'd0);
        set_data(32'd6, ~32'd1);
        wait_held("skew_held");
        check("skew_no_valid", {63'd0, word_valid}, 64'd0);
        set_null(~32'd1);
        model_push(32'd6);
        wait_launch("skew_launch");
        tick(2);

        // backpressure
        do_reset();
        word_ready = 1'b0;
        wavefront(32'd5, ALL1, 0, 0);
        set_data(32'd6, ALL1);
        wait_held("bp_held");
        set_null(ALL1);
        model_push(32'd6);
        tick(10);
        check("bp_word", {32'd0, word}, 64'd5);
        check("bp_valid", {63'd0, word_valid}, 64'd1);
        check("bp_acks", {32'd0, sumcomp}, {32'd0, ALL1});
        word_ready = 1'b1;
        tick(1);
        check("bp_word6", {32'd0, word}, 64'd6);
        check("bp_valid6", {63'd0, word_valid}, 64'd1);
        check("bp_drop", {32'd0, sumcomp}, 64'd0);
        tick(2);

        // sequence check and wrap
        do_reset();
        wavefront(32'hFFFF_FFFF, ALL1, 0, 0);
        wavefront(32'h0000_0000, ALL1, 0, 0);
        check("seq_wrap", {63'd0, seq_error}, 64'd0);
        wavefront(32'd5, ALL1, 0, 0);
        wavefront(32'd7, ALL1, 0, 0);
        check("seq_skip", {63'd0, seq_error}, 64'd1);
        wavefront(32'd8, ALL1, 0, 0);
        check("seq_sticky", {63'd0, seq_error}, 64'd1);
        tick(2);
        do_reset();

        // illegal code on digit 3
        sum_in[7:6] = 2'b11;
        tick(6);
        check("code_set", {63'd0, code_error}, 64'd1);
        check("code_lane_req", {32'd0, sumcomp}, 64'd0);
        sum_in = '0;
        tick(4);
        check("code_sticky", {63'd0, code_error}, 64'd1);
        do_reset();

        // randomized words, skew and ready
        rand_ready = 1'b1;
        repeat (40) begin
            w    = ($urandom_range(0, 3) != 0) ? (m_prev + 32'd1) : $urandom;
            mask = $urandom;
            wavefront(w, mask, $urandom_range(0, 6), $urandom_range(0, 6));
        end
        rand_ready = 1'b0;
        tick(1);
        word_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
